// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - packed word to MSB-first byte stream with optional XOR checksum byte
//
// Ports:
//   clk       input   rising-edge clock
//   rstN      input   asynchronous active-low reset
//   inWord    input   packed word, 8*NUM_BYTES bits, MSB byte sent first
//   inValid   input   inWord valid
//   inReady   output  high only in IDLE; decoded from registered state
//   outByte   output  current byte (registered)
//   outValid  output  outByte valid (registered)
//   outReady  input   downstream accepts outByte
//   outLast   output  final byte of the frame (registered)
module word_serializer #(
    parameter int NUM_BYTES   = 4,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [8*NUM_BYTES-1:0] inWord,
    input  logic                   inValid,
    output logic                   inReady,
    output logic [7:0]             outByte,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   outLast
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDX_W-1:0] PENU_IDX = IDX_W'(NUM_BYTES - 2);

    typedef enum logic [1:0] {IDLE, DATA, CSUM} state_t;

    state_t           state_q;
    logic [W-1:0]     word_q;   // remaining bytes, next one sits in the top byte
    logic [7:0]       acc_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             last_q;

    logic [7:0]       acc_d;
    logic             last_data;

    assign acc_d     = acc_q ^ byte_q;
    assign last_data = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            word_q  <= '0;
            acc_q   <= 8'h00;
            idx_q   <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inValid) begin
                        // Top byte goes straight to the output register; the
                        // rest is pre-shifted so the next byte is on top.
                        byte_q  <= inWord[W-1 -: 8];
                        word_q  <= inWord << 8;
                        acc_q   <= 8'h00;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (outReady) begin
                        acc_q <= acc_d;
                        if (last_data) begin
                            if (CHECKSUM_EN) begin
                                byte_q  <= acc_d;
                                last_q  <= 1'b1;
                                state_q <= CSUM;
                            end else begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            byte_q <= word_q[W-1 -: 8];
                            word_q <= word_q << 8;
                            // Without a checksum the last data byte closes the frame.
                            last_q <= !CHECKSUM_EN && (idx_q == PENU_IDX);
                        end
                    end
                end
                CSUM: begin
                    if (outReady) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outByte  = byte_q;
    assign outValid = valid_q;
    assign outLast  = last_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - directed self-checking bench for word_serializer
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rstN;

    logic [31:0] inWord0;
    logic        inValid0;
    logic        inReady0;
    logic [7:0]  outByte0;
    logic        outValid0;
    logic        outReady0;
    logic        outLast0;

    logic [31:0] inWord1;
    logic        inValid1;
    logic        inReady1;
    logic [7:0]  outByte1;
    logic        outValid1;
    logic        outReady1;
    logic        outLast1;

    int checks   = 0;
    int failures = 0;

    int cyc_n    = 0;
    int last_acc = 0;
    int period   = 0;

    always #5 clk = ~clk;

    word_serializer #(.NUM_BYTES(4), .CHECKSUM_EN(1'b1)) dut0 (
        .clk      (clk),
        .rstN     (rstN),
        .inWord   (inWord0),
        .inValid  (inValid0),
        .inReady  (inReady0),
        .outByte  (outByte0),
        .outValid (outValid0),
        .outReady (outReady0),
        .outLast  (outLast0)
    );

    word_serializer #(.NUM_BYTES(4), .CHECKSUM_EN(1'b0)) dut1 (
        .clk      (clk),
        .rstN     (rstN),
        .inWord   (inWord1),
        .inValid  (inValid1),
        .inReady  (inReady1),
        .outByte  (outByte1),
        .outValid (outValid1),
        .outReady (outReady1),
        .outLast  (outLast1)
    );

    // Cycle distance between consecutive accepts on dut0.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rstN && inValid0 && inReady0) begin
            period   <= cyc_n - last_acc;
            last_acc <= cyc_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of the first DATA cycle. Expects the four
    // data bytes of w then their XOR; bp selects the 1,0,0,1,0,1 ready pattern.
    task automatic recv0(input logic [31:0] w, input bit bp);
        logic [7:0] b [5];
        bit         pat [6];
        int         k;
        int         cyc;
        bit         r;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        k   = 0;
        cyc = 0;
        while (k < 5 && cyc < 50) begin
            r = bp ? pat[cyc % 6] : 1'b1;
            outReady0 = r;
            chk($sformatf("byte%0d", k), {24'h0, outByte0}, {24'h0, b[k]});
            chk($sformatf("valid%0d", k), {31'h0, outValid0}, 32'd1);
            chk($sformatf("last%0d", k), {31'h0, outLast0}, {31'h0, (k == 4)});
            chk($sformatf("busy%0d", k), {31'h0, inReady0}, 32'd0);
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        chk("frame_timeout", {31'h0, (cyc < 50)}, 32'd1);
        chk("idle_valid", {31'h0, outValid0}, 32'd0);
        chk("idle_ready", {31'h0, inReady0}, 32'd1);
    endtask

    initial begin
        rstN      = 1'b0;
        inWord0   = '0;
        inValid0  = 1'b0;
        outReady0 = 1'b0;
        inWord1   = '0;
        inValid1  = 1'b0;
        outReady1 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_inReady", {31'h0, inReady0}, 32'd1);
        chk("rst_outValid", {31'h0, outValid0}, 32'd0);
        chk("rst_outLast", {31'h0, outLast0}, 32'd0);
        chk("rst_outByte", {24'h0, outByte0}, 32'h0);
        rstN = 1'b1;

        // Basic frame
        inWord0  = 32'h01020345;
        inValid0 = 1'b1;
        outReady0 = 1'b1;
        @(negedge clk);
        inValid0 = 1'b0;
        recv0(32'h01020345, 1'b0);

        // Backpressure
        inWord0  = 32'h01020345;
        inValid0 = 1'b1;
        outReady0 = 1'b0;
        @(negedge clk);
        inValid0 = 1'b0;
        recv0(32'h01020345, 1'b1);

        // No checksum
        inWord1   = 32'hDEADBEEF;
        inValid1  = 1'b1;
        outReady1 = 1'b1;
        @(negedge clk);
        inValid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = 32'hDEADBEEF;
            chk($sformatf("nc_byte%0d", k), {24'h0, outByte1}, {24'h0, w[31-8*k -: 8]});
            chk($sformatf("nc_last%0d", k), {31'h0, outLast1}, {31'h0, (k == 3)});
            chk($sformatf("nc_valid%0d", k), {31'h0, outValid1}, 32'd1);
            @(negedge clk);
        end
        chk("nc_idle_valid", {31'h0, outValid1}, 32'd0);
        chk("nc_idle_ready", {31'h0, inReady1}, 32'd1);

        // Busy-ignore
        inWord0  = 32'h11223344;
        inValid0 = 1'b1;
        outReady0 = 1'b1;
        @(negedge clk);
        inWord0 = 32'hAAAAAAAA;
        recv0(32'h11223344, 1'b0);
        @(negedge clk);
        inValid0 = 1'b0;
        recv0(32'hAAAAAAAA, 1'b0);

        // Reset mid-frame
        inWord0  = 32'h01020345;
        inValid0 = 1'b1;
        outReady0 = 1'b1;
        @(negedge clk);
        inValid0 = 1'b0;
        chk("mr_byte0", {24'h0, outByte0}, 32'h01);
        @(negedge clk);
        chk("mr_byte1", {24'h0, outByte0}, 32'h02);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("mr_outValid", {31'h0, outValid0}, 32'd0);
        chk("mr_inReady", {31'h0, inReady0}, 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        inWord0  = 32'hFF000000;
        inValid0 = 1'b1;
        @(negedge clk);
        inValid0 = 1'b0;
        recv0(32'hFF000000, 1'b0);

        // Back-to-back with inValid held high
        inWord0  = 32'h01020345;
        inValid0 = 1'b1;
        outReady0 = 1'b1;
        @(negedge clk);
        inWord0 = 32'h0A0B0C0D;
        recv0(32'h01020345, 1'b0);
        @(negedge clk);
        inValid0 = 1'b0;
        chk("b2b_period", period, 32'd6);
        recv0(32'h0A0B0C0D, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
